// File: rtl/z80_uart_port.sv
// Z80 I/O-space COM port: data/status ports on the CPU bus,
// 8N1 UART line side with TX holding + shift and one RX buffer.
module z80_uart_port #(
  parameter logic [7:0] DATA_PORT = 8'hEF,
  parameter logic [7:0] STAT_PORT = 8'hEE,
  parameter int         BAUD_DIV  = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iorq,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] A,
  inout  wire  [7:0] D,
  output logic       txd,
  input  logic       rxd,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [15:0] BD_M1   = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);

  logic       wr_sel;
  logic       rd_dat;
  logic       rd_st;
  logic [1:0] wr_q;
  logic [1:0] rdd_q;
  logic [1:0] rds_q;
  logic       wr_load;
  logic       dat_end;
  logic       st_end;

  logic       rx_ready;
  logic       overrun;
  logic       framing_err;
  logic       tx_empty;
  logic [7:0] rx_buf;
  logic [7:0] status;

  assign wr_sel = ~iorq & ~wr & (A == DATA_PORT);
  assign rd_dat = ~iorq & ~rd & (A == DATA_PORT);
  assign rd_st  = ~iorq & ~rd & (A == STAT_PORT);

  assign status = {4'b0000, framing_err, overrun,
                   tx_empty, rx_ready};

  assign D = rd_dat ? rx_buf :
             rd_st  ? status : 8'bz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= 2'b00;
      rdd_q <= 2'b00;
      rds_q <= 2'b00;
    end else begin
      wr_q  <= {wr_q[0], wr_sel};
      rdd_q <= {rdd_q[0], rd_dat};
      rds_q <= {rds_q[0], rd_st};
    end
  end

  // one pulse per bus cycle: write at start, read effects at end
  assign wr_load = wr_q[0] & ~wr_q[1];
  assign dat_end = rdd_q[1] & ~rdd_q[0];
  assign st_end  = rds_q[1] & ~rds_q[0];

  // ---------------- transmitter ----------------
  state_t      tx_state;
  state_t      tx_next;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_sh;
  logic [7:0]  thr;
  logic        tx_tick;
  logic        tx_take;

  assign tx_tick = (tx_cnt == 16'd0);
  assign tx_take = ~tx_empty &
                   ((tx_state == S_IDLE) |
                    ((tx_state == S_STOP) & tx_tick));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tx_state <= S_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:
        if (~tx_empty) tx_next = S_START;
      S_START:
        if (tx_tick) tx_next = S_DATA;
      S_DATA:
        if (tx_tick && tx_idx == 3'd7)
          tx_next = S_STOP;
      S_STOP:
        if (tx_tick)
          tx_next = tx_empty ? S_IDLE : S_START;
      default: tx_next = S_IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (tx_state)
      S_START: txd = 1'b0;
      S_DATA:  txd = tx_sh[0];
      default: txd = 1'b1;
    endcase
    busy = (tx_state != S_IDLE) | ~tx_empty;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_cnt <= 16'd0;
      tx_idx <= 3'd0;
      tx_sh  <= 8'h00;
    end else if (tx_take) begin
      tx_sh  <= thr;
      tx_cnt <= BD_M1;
      tx_idx <= 3'd0;
    end else if (tx_state != S_IDLE) begin
      if (tx_tick) begin
        tx_cnt <= BD_M1;
        if (tx_state == S_DATA) begin
          tx_sh  <= {1'b0, tx_sh[7:1]};
          tx_idx <= tx_idx + 3'd1;
        end
      end else begin
        tx_cnt <= tx_cnt - 16'd1;
      end
    end
  end

  // take and CPU load are exclusive: take needs tx_empty=0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_empty <= 1'b1;
      thr      <= 8'h00;
    end else if (tx_take) begin
      tx_empty <= 1'b1;
    end else if (wr_load && tx_empty) begin
      thr      <= D;
      tx_empty <= 1'b0;
    end
  end

  // ---------------- receiver ----------------
  state_t      rx_state;
  state_t      rx_next;
  logic [2:0]  rx_s;
  logic        rx_in;
  logic        rx_fall;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_sh;
  logic        rx_tick;
  logic        rx_done;
  logic        rx_store;

  assign rx_in   = rx_s[1];
  assign rx_fall = rx_s[2] & ~rx_s[1];
  assign rx_tick = (rx_cnt == 16'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_s <= 3'b111;
    else        rx_s <= {rx_s[1:0], rxd};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_state <= S_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:
        if (rx_fall) rx_next = S_START;
      S_START:
        if (rx_tick)
          rx_next = rx_in ? S_IDLE : S_DATA;
      S_DATA:
        if (rx_tick && rx_idx == 3'd7)
          rx_next = S_STOP;
      S_STOP:
        if (rx_tick) rx_next = S_IDLE;
      default: rx_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_done  = (rx_state == S_STOP) & rx_tick;
    rx_store = rx_done & (~rx_ready | dat_end);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt <= 16'd0;
      rx_idx <= 3'd0;
      rx_sh  <= 8'h00;
    end else if (rx_state == S_IDLE) begin
      if (rx_fall) begin
        rx_cnt <= HALF_M1;
        rx_idx <= 3'd0;
      end
    end else if (rx_tick) begin
      rx_cnt <= BD_M1;
      if (rx_state == S_DATA) begin
        rx_sh  <= {rx_in, rx_sh[7:1]};
        rx_idx <= rx_idx + 3'd1;
      end
    end else begin
      rx_cnt <= rx_cnt - 16'd1;
    end
  end

  // new-byte and overrun sets take priority over read clears
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_ready    <= 1'b0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
      rx_buf      <= 8'h00;
    end else begin
      if (rx_store) begin
        rx_buf      <= rx_sh;
        rx_ready    <= 1'b1;
        framing_err <= ~rx_in;
      end else begin
        if (dat_end) rx_ready    <= 1'b0;
        if (st_end)  framing_err <= 1'b0;
      end
      if (rx_done && !rx_store) overrun <= 1'b1;
      else if (st_end)          overrun <= 1'b0;
    end
  end

endmodule
